// File: rtl/conv_tile_ctrl.sv
// conv_tile_ctrl: sequences one 3x3 convolution over a 6x6 input tile into a
// 4x4 result buffer, then streams the 2x2 max-pooled, ReLU-clamped results.
`timescale 1ns/1ps
module conv_tile_ctrl #(
  parameter int K   = 3,
  parameter int OUT = 4,
  parameter int IN  = 6
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                start,
  output logic                busy,
  output logic                done,
  output logic                ifm_rd,
  output logic [5:0]          ifm_addr,
  input  logic signed [31:0]  ifm_rdata,
  output logic [3:0]          wt_addr,
  input  logic signed [31:0]  wt_rdata,
  output logic                out_valid,
  input  logic                out_ready,
  output logic signed [31:0]  out_data,
  output logic [1:0]          out_idx
);

  localparam int DATA_W = 32;
  localparam int POOL_N = (OUT / 2) * (OUT / 2);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    RUN    = 2'd1,
    DRAIN  = 2'd2,
    OUTPUT = 2'd3
  } state_t;

  // Two's-complement multiply-accumulate; the low DATA_W bits are kept.
  function automatic logic signed [DATA_W-1:0] mac(
    input logic signed [DATA_W-1:0] acc,
    input logic signed [DATA_W-1:0] a,
    input logic signed [DATA_W-1:0] b,
    input logic                     load
  );
    logic signed [DATA_W-1:0] p;
    p = a * b;
    return load ? p : acc + p;
  endfunction

  // Signed maximum of two values.
  function automatic logic signed [DATA_W-1:0] smax(
    input logic signed [DATA_W-1:0] a,
    input logic signed [DATA_W-1:0] b
  );
    return (a > b) ? a : b;
  endfunction

  // Clamp negative values to zero.
  function automatic logic signed [DATA_W-1:0] relu(
    input logic signed [DATA_W-1:0] a
  );
    return a[DATA_W-1] ? '0 : a;
  endfunction

  state_t state_q, state_d;

  // Read-side loop counters: output pixel (r,c) and kernel tap (ky,kx).
  logic [1:0] r_q, r_d;
  logic [1:0] c_q, c_d;
  logic [1:0] ky_q, ky_d;
  logic [1:0] kx_q, kx_d;

  logic [1:0] idx_q, idx_d;
  logic       done_q, done_d;

  logic       last_tap;
  logic       last_read;
  logic       xfer;
  logic [5:0] row_w;
  logic [5:0] col_w;
  logic [5:0] rd_addr;
  logic [3:0] rd_tap;

  // Return-side stage: tags travelling with the read issued one cycle ago.
  logic       vld_p0_q;
  logic       first_p0_q;
  logic       last_p0_q;
  logic [3:0] pix_p0_q;

  logic signed [DATA_W-1:0] acc_q, acc_d;
  logic signed [DATA_W-1:0] sum_p0;
  logic signed [DATA_W-1:0] tile_q [OUT*OUT];
  logic signed [DATA_W-1:0] pool_max;

  assign last_tap  = (kx_q == 2'(K - 1)) && (ky_q == 2'(K - 1));
  assign last_read = last_tap && (c_q == 2'(OUT - 1)) && (r_q == 2'(OUT - 1));
  assign xfer      = (state_q == OUTPUT) && out_ready;

  assign row_w   = {4'd0, r_q} + {4'd0, ky_q};
  assign col_w   = {4'd0, c_q} + {4'd0, kx_q};
  assign rd_addr = row_w * 6'(IN) + col_w;
  assign rd_tap  = {2'd0, ky_q} * 4'(K) + {2'd0, kx_q};

  // State register with asynchronous reset to IDLE.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state decode: 144 reads, one drain cycle, then four pooled results.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (start) state_d = RUN;
      RUN:     if (last_read) state_d = DRAIN;
      DRAIN:   state_d = OUTPUT;
      OUTPUT:  if (out_ready && (idx_q == 2'(POOL_N - 1))) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Nested read counters: kx innermost, then ky, then c, then r.
  always_comb begin
    r_d  = r_q;
    c_d  = c_q;
    ky_d = ky_q;
    kx_d = kx_q;
    if ((state_q == IDLE) && start) begin
      r_d  = 2'd0;
      c_d  = 2'd0;
      ky_d = 2'd0;
      kx_d = 2'd0;
    end else if (state_q == RUN) begin
      if (kx_q == 2'(K - 1)) begin
        kx_d = 2'd0;
        if (ky_q == 2'(K - 1)) begin
          ky_d = 2'd0;
          if (c_q == 2'(OUT - 1)) begin
            c_d = 2'd0;
            r_d = (r_q == 2'(OUT - 1)) ? 2'd0 : r_q + 2'd1;
          end else begin
            c_d = c_q + 2'd1;
          end
        end else begin
          ky_d = ky_q + 2'd1;
        end
      end else begin
        kx_d = kx_q + 2'd1;
      end
    end
  end

  // Pooled-result index and the done pulse that follows the final transfer.
  always_comb begin
    idx_d  = idx_q;
    done_d = 1'b0;
    if ((state_q == IDLE) && start) begin
      idx_d = 2'd0;
    end else if (xfer) begin
      idx_d  = idx_q + 2'd1;
      done_d = (idx_q == 2'(POOL_N - 1));
    end
  end

  // Control counters and the done flag.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_q    <= 2'd0;
      c_q    <= 2'd0;
      ky_q   <= 2'd0;
      kx_q   <= 2'd0;
      idx_q  <= 2'd0;
      done_q <= 1'b0;
    end else begin
      r_q    <= r_d;
      c_q    <= c_d;
      ky_q   <= ky_d;
      kx_q   <= kx_d;
      idx_q  <= idx_d;
      done_q <= done_d;
    end
  end

  // ---- stage p0: SRAM data returns one cycle after the read strobe ----
  // Tag each read so the returning data knows its tap and destination pixel.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_p0_q   <= 1'b0;
      first_p0_q <= 1'b0;
      last_p0_q  <= 1'b0;
      pix_p0_q   <= 4'd0;
    end else begin
      vld_p0_q   <= (state_q == RUN);
      first_p0_q <= (kx_q == 2'd0) && (ky_q == 2'd0);
      last_p0_q  <= last_tap;
      pix_p0_q   <= {r_q, c_q};
    end
  end

  // Tap 0 loads the product directly, so no clear cycle is needed per pixel.
  assign sum_p0 = mac(acc_q, ifm_rdata, wt_rdata, first_p0_q);
  assign acc_d  = vld_p0_q ? sum_p0 : acc_q;

  // Accumulator register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_q <= '0;
    end else begin
      acc_q <= acc_d;
    end
  end

  // ---- stage p1: completed pixel sums land in the tile buffer ----
  // Every entry is rewritten each tile before OUTPUT reads it, so no reset.
  always_ff @(posedge clk) begin
    if (vld_p0_q && last_p0_q) begin
      tile_q[pix_p0_q] <= sum_p0;
    end
  end

  // 2x2 block for index {pr,pc}: buffer rows {pr,dr}, columns {pc,dc}.
  assign pool_max = smax(smax(tile_q[{idx_q[1], 1'b0, idx_q[0], 1'b0}],
                              tile_q[{idx_q[1], 1'b0, idx_q[0], 1'b1}]),
                         smax(tile_q[{idx_q[1], 1'b1, idx_q[0], 1'b0}],
                              tile_q[{idx_q[1], 1'b1, idx_q[0], 1'b1}]));

  // Output decode: strobes and data are forced to zero outside their states.
  always_comb begin
    busy      = (state_q != IDLE);
    done      = done_q;
    ifm_rd    = 1'b0;
    ifm_addr  = 6'd0;
    wt_addr   = 4'd0;
    out_valid = 1'b0;
    out_data  = '0;
    out_idx   = 2'd0;
    if (state_q == RUN) begin
      ifm_rd   = 1'b1;
      ifm_addr = rd_addr;
      wt_addr  = rd_tap;
    end
    if (state_q == OUTPUT) begin
      out_valid = 1'b1;
      out_data  = relu(pool_max);
      out_idx   = idx_q;
    end
  end

endmodule

// File: tb/tb_conv_tile_ctrl.sv
// tb_conv_tile_ctrl: randomized and directed tiles against a tile-level
// reference model of the convolution / pooling controller.
`timescale 1ns/1ps
module tb_conv_tile_ctrl;

  logic               clk = 1'b0;
  logic               rst_n = 1'b0;
  logic               start = 1'b0;
  logic               out_ready = 1'b0;
  logic               busy, done, ifm_rd, out_valid;
  logic [5:0]         ifm_addr;
  logic [3:0]         wt_addr;
  logic [1:0]         out_idx;
  logic signed [31:0] ifm_rdata = '0;
  logic signed [31:0] wt_rdata = '0;
  logic signed [31:0] out_data;

  always #5 clk = ~clk;

  conv_tile_ctrl #(.K(3), .OUT(4), .IN(6)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .busy      (busy),
    .done      (done),
    .ifm_rd    (ifm_rd),
    .ifm_addr  (ifm_addr),
    .ifm_rdata (ifm_rdata),
    .wt_addr   (wt_addr),
    .wt_rdata  (wt_rdata),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_idx   (out_idx)
  );

  logic signed [31:0] pix_mem [36];
  logic signed [31:0] wt_mem  [9];

  // SRAM stand-ins: data valid only in the cycle after a read, garbage otherwise.
  always @(posedge clk) begin
    if (ifm_rd) begin
      ifm_rdata <= (ifm_addr < 6'd36) ? pix_mem[ifm_addr] : 32'sd0;
      wt_rdata  <= (wt_addr < 4'd9) ? wt_mem[wt_addr] : 32'sd0;
    end else begin
      ifm_rdata <= $urandom;
      wt_rdata  <= $urandom;
    end
  end

  int n_pass = 0;
  int n_chk  = 0;

  task automatic chk(input string name, input longint act, input longint exp);
    n_chk++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
  endtask

  // Reference model state.
  bit                 m_act = 1'b0;
  bit                 m_done = 1'b0;
  int                 m_t = 0;
  int                 m_x = 0;
  int                 last_done_t = -1;
  int                 exp_pool [4];
  logic signed [31:0] got [$];

  // Whole-tile result from the arithmetic definition of conv, pool and ReLU.
  function automatic void compute_expected();
    int conv [4][4];
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++) begin
        int s;
        s = 0;
        for (int ky = 0; ky < 3; ky++)
          for (int kx = 0; kx < 3; kx++)
            s = s + pix_mem[(r + ky) * 6 + c + kx] * wt_mem[ky * 3 + kx];
        conv[r][c] = s;
      end
    for (int pr = 0; pr < 2; pr++)
      for (int pc = 0; pc < 2; pc++) begin
        int m;
        m = conv[2*pr][2*pc];
        if (conv[2*pr][2*pc+1] > m) m = conv[2*pr][2*pc+1];
        if (conv[2*pr+1][2*pc] > m) m = conv[2*pr+1][2*pc];
        if (conv[2*pr+1][2*pc+1] > m) m = conv[2*pr+1][2*pc+1];
        exp_pool[pr*2+pc] = (m < 0) ? 0 : m;
      end
  endfunction

  // Per-cycle compare against the model, then advance the model.
  initial begin
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_ifm_rd", ifm_rd, 0);
        chk("rst_ifm_addr", ifm_addr, 0);
        chk("rst_wt_addr", wt_addr, 0);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_out_data", out_data, 0);
        chk("rst_out_idx", out_idx, 0);
        m_act  = 1'b0;
        m_done = 1'b0;
      end else begin
        bit e_rd, e_val, nd;
        int p, k;
        e_rd  = m_act && (m_t >= 1) && (m_t <= 144);
        e_val = m_act && (m_t >= 146);
        chk("busy", busy, m_act);
        chk("done", done, m_done);
        chk("ifm_rd", ifm_rd, e_rd);
        chk("out_valid", out_valid, e_val);
        if (e_rd) begin
          p = (m_t - 1) / 9;
          k = (m_t - 1) % 9;
          chk("ifm_addr", ifm_addr, (p / 4 + k / 3) * 6 + (p % 4 + k % 3));
          chk("wt_addr", wt_addr, k);
        end
        if (e_val && m_x < 4) begin
          chk("out_idx", out_idx, m_x);
          chk("out_data", out_data, exp_pool[m_x]);
        end
        if (done) last_done_t = m_t;
        nd = 1'b0;
        if (m_act) begin
          if (m_t >= 146 && out_ready) begin
            got.push_back(out_data);
            m_x++;
            if (m_x == 4) begin
              m_act = 1'b0;
              nd    = 1'b1;
            end
          end
          m_t++;
        end else if (start) begin
          m_act = 1'b1;
          m_t   = 1;
          m_x   = 0;
          last_done_t = -1;
          compute_expected();
        end
        m_done = nd;
      end
    end
  end

  // mode 0: ready high; 1: random ready; 2: ready low for cycles 147..151.
  task automatic run_tile(input int mode, input int glitch_at, input int exp_lat);
    bit seen;
    got.delete();
    @(posedge clk); #1;
    start = 1'b1;
    out_ready = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    seen = 1'b0;
    for (int cyc = 1; cyc <= 600 && !seen; cyc++) begin
      case (mode)
        0:       out_ready = 1'b1;
        1:       out_ready = ($urandom_range(0, 3) != 0);
        default: out_ready = !(cyc >= 147 && cyc <= 151);
      endcase
      start = (cyc == glitch_at);
      @(negedge clk);
      if (done) seen = 1'b1;
      @(posedge clk); #1;
    end
    start = 1'b0;
    if (!seen) chk("done_timeout", 0, 1);
    else if (exp_lat > 0) chk("latency", last_done_t, exp_lat);
  endtask

  task automatic chk_got(input int a, input int b, input int c, input int d);
    int e [4];
    e = '{a, b, c, d};
    chk("result_count", got.size(), 4);
    for (int i = 0; i < 4 && i < got.size(); i++) chk("result_literal", got[i], e[i]);
  endtask

  task automatic fill(input int pmode, input int wmode);
    for (int i = 0; i < 36; i++) begin
      int v;
      case (pmode)
        0: v = 1;
        1: v = i;
        2: v = 32'h4000_0000;
        3: v = $urandom;
        default: v = int'($urandom_range(0, 200)) - 100;
      endcase
      pix_mem[i] = v;
    end
    for (int k = 0; k < 9; k++) begin
      int v;
      case (wmode)
        0: v = 1;
        1: v = (k == 0) ? 1 : 0;
        2: v = -1;
        3: v = (k == 0) ? 4 : 0;
        4: v = $urandom;
        default: v = int'($urandom_range(0, 20)) - 10;
      endcase
      wt_mem[k] = v;
    end
  endtask

  initial begin
    fill(0, 0);
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    repeat (3) @(posedge clk);

    fill(0, 0);
    run_tile(0, 0, 150);
    chk("model_pin_ones", exp_pool[0], 9);
    chk_got(9, 9, 9, 9);

    fill(1, 1);
    run_tile(0, 0, 150);
    chk("model_pin_addr", exp_pool[2], 19);
    chk_got(7, 9, 19, 21);

    fill(0, 2);
    run_tile(0, 0, 150);
    chk_got(0, 0, 0, 0);

    fill(2, 3);
    run_tile(0, 0, 150);
    chk_got(0, 0, 0, 0);

    fill(1, 1);
    run_tile(2, 0, 155);
    chk_got(7, 9, 19, 21);

    fill(4, 5);
    run_tile(0, 50, 150);

    // Reset in the middle of read 70, then a fresh tile from address 0.
    fill(3, 4);
    @(posedge clk); #1;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (69) @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("async_rst_busy", busy, 0);
    chk("async_rst_ifm_rd", ifm_rd, 0);
    chk("async_rst_ifm_addr", ifm_addr, 0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    repeat (5) @(posedge clk);
    run_tile(0, 0, 150);

    for (int t = 0; t < 6; t++) begin
      if (t % 2 == 0) fill(3, 4);
      else fill(5, 5);
      run_tile(1, 0, 0);
      chk("random_result_count", got.size(), 4);
    end

    repeat (3) @(posedge clk);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/conv_tile_ctrl.md
CONV_TILE_CTRL -- requirements
Module: conv_tile_ctrl

Interface
REQ-001 Parameter K, 3, kernel side; the only supported value is 3.
REQ-002 Parameter OUT, 4, output tile side; the only supported value is 4.
REQ-003 Parameter IN, 6, input tile side; SHALL equal OUT+K-1.
REQ-004 clk  in  1  clock; all state SHALL update on the rising edge.
REQ-005 rst_n  in  1  reset; asynchronous, active-low.
REQ-006 start  in  1  one-cycle request to process one tile; sampled only in IDLE.
REQ-007 busy  out  1  high in every state other than IDLE.
REQ-008 done  out  1  one-cycle pulse after the last pooled result handshakes.
REQ-009 ifm_rd  out  1  input feature-map SRAM read strobe.
REQ-010 ifm_addr  out  6  input feature-map address, row-major, row*IN+col.
REQ-011 ifm_rdata  in  32  signed input pixel, valid exactly 1 cycle after ifm_rd.
REQ-012 wt_addr  out  4  weight SRAM address, ky*K+kx; shares the ifm_rd strobe.
REQ-013 wt_rdata  in  32  signed weight, valid exactly 1 cycle after ifm_rd.
REQ-014 out_valid  out  1  pooled result valid.
REQ-015 out_ready  in  1  downstream accepts; a transfer occurs when out_valid and out_ready are both high.
REQ-016 out_data  out  32  signed, ReLU(max-pool) result.
REQ-017 out_idx  out  2  pooled position, value pr*2+pc.

Function
REQ-018 The FSM SHALL have the states IDLE, RUN, DRAIN and OUTPUT.
REQ-019 Transition IDLE->RUN SHALL occur on start=1; start SHALL be ignored in any state other than IDLE.
REQ-020 RUN SHALL issue exactly 144 back-to-back reads, with ifm_rd high on each.
- Order: output pixel (r,c) row-major over r,c in 0..3.
- Inner order: tap k=ky*3+kx, k in 0..8.
- ifm_addr=(r+ky)*6+(c+kx); wt_addr=k.
REQ-021 If start is sampled at edge T, ifm_rd SHALL be high for the 144 cycles that follow edge T.
REQ-022 After the 144th read, the FSM SHALL spend one cycle in DRAIN, then enter OUTPUT.
REQ-023 The accumulator SHALL load ifm_rdata*wt_rdata for the returned data of tap 0, with no clear cycle and no dependence on the previous pixel.
REQ-024 The accumulator SHALL add ifm_rdata*wt_rdata to its value for taps 1..8.
REQ-025 When tap 8's data accumulates, the sum SHALL be written to the 4x4 tile buffer entry [r][c].
REQ-026 Products and sums SHALL keep the low 32 bits (two's-complement wrap) with no saturation.
REQ-027 OUTPUT SHALL present idx 0..3 in order.
- out_data = max over the 2x2 block rows 2pr..2pr+1, cols 2pc..2pc+1, using a signed compare.
- A negative max SHALL be replaced by 0.
REQ-028 Each result transfer SHALL advance idx; out_valid SHALL stay high between transfers.
REQ-029 While out_valid=1 and out_ready=0, out_data and out_idx SHALL hold stable.
REQ-030 On the idx-3 transfer, the FSM SHALL move to IDLE and done SHALL pulse for 1 cycle (the cycle after the transfer).
REQ-031 ifm_rd SHALL be 0 in IDLE, DRAIN and OUTPUT; out_valid SHALL be 0 outside OUTPUT.
REQ-032 With out_ready held high, the latency from start to done SHALL be 150 cycles: 144 RUN + 1 DRAIN + 4 OUTPUT + 1.

Reset
REQ-033 rst_n=0 SHALL asynchronously force IDLE from any state, including mid-RUN and mid-OUTPUT.
REQ-034 During reset, all of the following SHALL be 0:
- busy, done, ifm_rd, ifm_addr, wt_addr;
- out_valid, out_data, out_idx;
- the accumulator and all counters.
REQ-035 Tile buffer contents need not be reset; they SHALL be fully rewritten before any read.
REQ-036 After release, no read or output SHALL occur until a new start.

Verification
REQ-037 Bench scenarios:
- All pixels=1, all weights=1, out_ready=1 -> out_data 9,9,9,9 at idx 0..3; done at cycle 150.
- Pixel(i)=address i, weights=1 at k=0 else 0 -> conv[r][c]=r*6+c; out_data 7,9,19,21.
- Weights=-1, pixels=1 -> every out_data=0 (ReLU).
- ifm=0x40000000, w=4 at k=0, others 0 -> conv wraps to 0; out_data 0.
- out_ready low for 5 cycles at idx 1 -> out_data/out_idx stable; no skipped or duplicate idx; done delayed 5 cycles.
- start pulsed mid-RUN -> ignored; rst_n low at read 70 -> all outputs 0 immediately; a new start gives the full 144-read sequence from address 0.
